// File: rtl/mdu_pkg.sv
// Shared MDU opcode encoding, default latencies and pending-result payload.
// Used by mdu, the instruction decoder and the hazard unit.
package mdu_pkg;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;
  localparam int unsigned XLEN         = 32;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_MADD  = 3'd7
  } mdu_op_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            we;
  } mdu_res_t;

endpackage

// File: rtl/mdu_cnt.sv
// Loadable busy down-counter; o_done_c marks the edge on which the result commits.
module mdu_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_lat,
  output logic             o_busy,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= i_lat;
      r_busy <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt  <= r_cnt - CNT_W'(1);
      r_busy <= (r_cnt != CNT_W'(1));
    end
  end

  assign o_busy   = r_busy;
  assign o_done_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO for the MIPS EX stage.
// Optional madd (opcode 7) is built only when MDU_MADD_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      MDUctr,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO,
  output logic            busy
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [XLEN-1:0]   r_hi, r_lo;
  mdu_res_t          r_pend;

  logic              w_busy, w_commit_c, w_accept;
  logic              w_load, w_wr_hi, w_wr_lo;
  logic [CNT_W-1:0]  w_lat;
  mdu_res_t          w_res;
  logic [2*XLEN-1:0] w_smul, w_umul;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_sq, w_sr;
`ifdef MDU_MADD_EN
  logic [2*XLEN-1:0] w_madd;
`endif

  assign w_accept = start & ~w_busy;

  assign w_smul = $signed({{XLEN{A[XLEN-1]}}, A}) * $signed({{XLEN{B[XLEN-1]}}, B});
  assign w_umul = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};

  // Signed divide via magnitudes; 0x80000000/-1 falls out as quotient 0x80000000, remainder 0.
  assign w_a_mag = A[XLEN-1] ? (~A + XLEN'(1)) : A;
  assign w_b_mag = B[XLEN-1] ? (~B + XLEN'(1)) : B;
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_sq    = (A[XLEN-1] ^ B[XLEN-1]) ? (~w_q_mag + XLEN'(1)) : w_q_mag;
  assign w_sr    = A[XLEN-1] ? (~w_r_mag + XLEN'(1)) : w_r_mag;

`ifdef MDU_MADD_EN
  assign w_madd = {r_hi, r_lo} + w_smul;
`endif

  // Opcode decode for an accepted start
  always_comb begin
    w_res   = '0;
    w_load  = 1'b0;
    w_lat   = '0;
    w_wr_hi = 1'b0;
    w_wr_lo = 1'b0;
    if (w_accept) begin
      case (mdu_op_e'(MDUctr))
        MDU_MULT: begin
          w_res  = '{hi: w_smul[2*XLEN-1:XLEN], lo: w_smul[XLEN-1:0], we: 1'b1};
          w_load = 1'b1;
          w_lat  = CNT_W'(MULT_LAT);
        end
        MDU_MULTU: begin
          w_res  = '{hi: w_umul[2*XLEN-1:XLEN], lo: w_umul[XLEN-1:0], we: 1'b1};
          w_load = 1'b1;
          w_lat  = CNT_W'(MULT_LAT);
        end
        MDU_DIV: begin
          w_res  = '{hi: w_sr, lo: w_sq, we: (B != '0)};
          w_load = 1'b1;
          w_lat  = CNT_W'(DIV_LAT);
        end
        MDU_DIVU: begin
          w_res  = '{hi: A % B, lo: A / B, we: (B != '0)};
          w_load = 1'b1;
          w_lat  = CNT_W'(DIV_LAT);
        end
`ifdef MDU_MADD_EN
        MDU_MADD: begin
          w_res  = '{hi: w_madd[2*XLEN-1:XLEN], lo: w_madd[XLEN-1:0], we: 1'b1};
          w_load = 1'b1;
          w_lat  = CNT_W'(MULT_LAT);
        end
`endif
        MDU_MTHI: w_wr_hi = 1'b1;
        MDU_MTLO: w_wr_lo = 1'b1;
        default: ;
      endcase
    end
  end

  mdu_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_lat    (w_lat),
    .o_busy   (w_busy),
    .o_done_c (w_commit_c)
  );

  // Commit and mthi/mtlo never coincide: busy is still high on the commit edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_pend <= '0;
    end else begin
      if (w_load) r_pend <= w_res;
      if (w_commit_c) begin
        if (r_pend.we) begin
          r_hi <= r_pend.hi;
          r_lo <= r_pend.lo;
        end
      end else begin
        if (w_wr_hi) r_hi <= A;
        if (w_wr_lo) r_lo <= A;
      end
    end
  end

  assign HI   = r_hi;
  assign LO   = r_lo;
  assign busy = w_busy;

endmodule
